// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the tone-memory game session sequencer.
//   state_e    : session sequencer states
//   NOTE_W     : bits per note inside a lane
//   LANE_W     : bits per lane in the pattern word
//   LANES      : lanes per pattern word
//   PATTERN_W  : width of one pattern word
//   SCORE_W    : width of the score / miss counters
// -----------------------------------------------------------------------------
package game_pkg;

  localparam int NOTE_W    = 3;
  localparam int LANE_W    = 4;
  localparam int LANES     = 8;
  localparam int PATTERN_W = 32;
  localparam int SCORE_W   = 5;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_SCORE,
    ST_DONE
  } state_e;

  // Keeps only the note bits of every lane, so the spare top bit is always 0.
  function automatic logic [PATTERN_W-1:0] note_mask();
    logic [PATTERN_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i*LANE_W +: NOTE_W] = '1;
    end
    return m;
  endfunction

  // Counter increment that sticks at the maximum value.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_round_ctrl_if
// Link between the session sequencer and the game core.
//   core_reset        : active-high reset to the core
//   core_data         : pattern word for the core data_in
//   core_write_enable : one-cycle load strobe
//   core_game_start   : one-cycle start strobe
//   core_game_end     : game_end returned by the core
// master = sequencer side, slave = core side.
// -----------------------------------------------------------------------------
interface game_round_ctrl_if;
  import game_pkg::*;

  logic                 core_reset;
  logic [PATTERN_W-1:0] core_data;
  logic                 core_write_enable;
  logic                 core_game_start;
  logic                 core_game_end;

  modport master (
    output core_reset,
    output core_data,
    output core_write_enable,
    output core_game_start,
    input  core_game_end
  );

  modport slave (
    input  core_reset,
    input  core_data,
    input  core_write_enable,
    input  core_game_start,
    output core_game_end
  );
endinterface

// File: rtl/song_pattern_rom.sv
// -----------------------------------------------------------------------------
// song_pattern_rom
// Combinational table of note patterns, one per round.
//   idx     in  4   round index
//   pattern out 32  8 lanes of 4 bits, note in [2:0], bit 3 forced to 0;
//                   indices at or above NUM_SONGS return 0
// -----------------------------------------------------------------------------
module song_pattern_rom
  import game_pkg::*;
#(
  parameter int NUM_SONGS = 4
) (
  input  logic [3:0]           idx,
  output logic [PATTERN_W-1:0] pattern
);

  localparam logic [PATTERN_W-1:0] MASK = note_mask();

  logic [PATTERN_W-1:0] raw;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    raw = '0;
    unique case (idx)
      4'd0:  raw = 32'h0123_4567;
      4'd1:  raw = 32'h7654_3210;
      4'd2:  raw = 32'h1357_0246;
      4'd3:  raw = 32'h6420_7531;
      4'd4:  raw = 32'h0011_2233;
      4'd5:  raw = 32'h4455_6677;
      4'd6:  raw = 32'h7766_5544;
      4'd7:  raw = 32'h3322_1100;
      4'd8:  raw = 32'h0707_0707;
      4'd9:  raw = 32'h1616_1616;
      4'd10: raw = 32'h2525_2525;
      4'd11: raw = 32'h3434_3434;
      4'd12: raw = 32'h0000_7777;
      4'd13: raw = 32'h7777_0000;
      4'd14: raw = 32'h1234_5670;
      4'd15: raw = 32'h0765_4321;
      default: raw = '0;
    endcase
  end

  assign pattern = ({28'd0, idx} < NUM_SONGS) ? (raw & MASK) : '0;

endmodule

// File: rtl/game_round_ctrl.sv
// -----------------------------------------------------------------------------
// game_round_ctrl
// Session sequencer: per round it resets the game core, loads one pattern,
// pulses start and waits for game_end or a timeout, keeping score/miss counts.
//   clk          in   system clock
//   reset        in   synchronous active-low reset
//   start_btn    in   level; rising edge starts a session from IDLE/DONE
//   abort        in   level; returns to IDLE from any other state
//   core         if   game_round_ctrl_if.master (core reset/data/strobes/end)
//   song_idx     out  current round index
//   score        out  rounds won (saturating)
//   miss_cnt     out  rounds timed out (saturating)
//   round_active out  high in RUN
//   session_done out  high in DONE
// All outputs are registered and decoded from the next state, so each output
// lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int NUM_SONGS       = 4,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int CORE_RST_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               abort,
  game_round_ctrl_if.master  core,
  output logic [3:0]         song_idx,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss_cnt,
  output logic               round_active,
  output logic               session_done
);

  // One timer serves both the CRST pulse length and the RUN timeout.
  localparam int TMAX    = (TIMEOUT_CYCLES > CORE_RST_CYCLES) ? TIMEOUT_CYCLES : CORE_RST_CYCLES;
  localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TIMER_W-1:0] CRST_LAST = TIMER_W'(CORE_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RUN_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         LAST_SONG = 4'(NUM_SONGS - 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           song_q, song_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   miss_q, miss_d;
  logic                 win_q, win_d;
  logic                 start_prev_q;
  logic                 start_edge;

  logic                 core_reset_q;
  logic                 core_we_q;
  logic                 core_start_q;
  logic [PATTERN_W-1:0] core_data_q;
  logic                 round_active_q;
  logic                 session_done_q;
  logic [PATTERN_W-1:0] rom_pattern;

  assign start_edge = start_btn & ~start_prev_q;

  // Addressed with the next index so the pattern is ready on CRST entry.
  song_pattern_rom #(.NUM_SONGS(NUM_SONGS)) u_rom (
    .idx     (song_d),
    .pattern (rom_pattern)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    song_d  = song_q;
    score_d = score_q;
    miss_d  = miss_q;
    win_d   = win_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          score_d = '0;
          miss_d  = '0;
          song_d  = '0;
          timer_d = '0;
          state_d = ST_CRST;
        end
      end
      ST_CRST: begin
        if (timer_q == CRST_LAST) state_d = ST_LOAD;
        else                      timer_d = timer_q + TIMER_W'(1);
      end
      ST_LOAD: state_d = ST_ARM;
      ST_ARM: begin
        timer_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // game_end wins over a timeout landing on the same cycle.
        if (core.core_game_end) begin
          win_d   = 1'b1;
          state_d = ST_SCORE;
        end else if (timer_q == RUN_LAST) begin
          win_d   = 1'b0;
          state_d = ST_SCORE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_SCORE: begin
        if (win_q) score_d = sat_inc(score_q);
        else       miss_d  = sat_inc(miss_q);
        if (song_q == LAST_SONG) begin
          state_d = ST_DONE;
        end else begin
          song_d  = song_q + 4'd1;
          timer_d = '0;
          state_d = ST_CRST;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides every other event; counters keep their values.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      song_d  = song_q;
      score_d = score_q;
      miss_d  = miss_q;
      timer_d = timer_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, and all state uses <= so every register updates from pre-edge values.
    if (!reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      song_q         <= '0;
      score_q        <= '0;
      miss_q         <= '0;
      win_q          <= 1'b0;
      start_prev_q   <= 1'b0;
      core_reset_q   <= 1'b1;
      core_we_q      <= 1'b0;
      core_start_q   <= 1'b0;
      core_data_q    <= '0;
      round_active_q <= 1'b0;
      session_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      song_q         <= song_d;
      score_q        <= score_d;
      miss_q         <= miss_d;
      win_q          <= win_d;
      start_prev_q   <= start_btn;
      core_reset_q   <= (state_d == ST_IDLE) || (state_d == ST_CRST) || (state_d == ST_DONE);
      core_we_q      <= (state_d == ST_LOAD);
      core_start_q   <= (state_d == ST_ARM);
      round_active_q <= (state_d == ST_RUN);
      session_done_q <= (state_d == ST_DONE);
      if (state_d == ST_CRST && state_q != ST_CRST) core_data_q <= rom_pattern;
    end
  end

  assign core.core_reset        = core_reset_q;
  assign core.core_data         = core_data_q;
  assign core.core_write_enable = core_we_q;
  assign core.core_game_start   = core_start_q;
  assign song_idx               = song_q;
  assign score                  = score_q;
  assign miss_cnt               = miss_q;
  assign round_active           = round_active_q;
  assign session_done           = session_done_q;

endmodule
